dmem_responder: RTL and testbench

Memory-side responder for the CPU's data-memory port. It accepts one load or store request at a time over a valid/ready handshake and services it after a programmable latency. Byte, halfword and word accesses are supported using the same `dsize` encoding the datapath drives. Each request returns exactly one response with right-justified read data or an error flag. It sits where a fixed single-cycle data memory would sit and lets the core be tested against a slow memory.

---
 rtl/dmem_responder_if.sv | 34 +++
 rtl/dmem_responder.sv | 152 +++++++++++++++
 tb/tb_dmem_responder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bundle between a CPU data port and a memory responder.
//   master : requester side (drives req_*, resp_ready)
//   slave  : responder side (drives req_ready, resp_*)
// Signals:
//   req_valid/req_ready   request handshake
//   req_write             1 = store, 0 = load
//   req_addr[31:0]        byte address
//   req_size[1:0]         00 byte, 01 halfword, 11 word, 10 illegal
//   req_wdata[31:0]       right-justified store data
//   resp_valid/resp_ready response handshake
//   resp_rdata[31:0]      right-justified load data, upper bits zero
//   resp_error            misaligned, out of range or illegal size
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_error;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_error
    );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder with a programmable access latency.
// Accepts one request at a time, counts down LATENCY edges, performs the big-endian
// access, then holds the response until the requester takes it.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    dmem_responder_if.slave (request/response handshake and data)
module dmem_responder #(
    parameter int unsigned SIZE    = 16384,
    parameter int unsigned LATENCY = 2
) (
    input logic             clock,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int unsigned AW = (SIZE > 1) ? $clog2(SIZE) : 1;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    // Storage is deliberately left out of reset.
    logic [7:0]  mem [SIZE];

    logic        access;
    logic        acc_err;
    logic [32:0] nbytes;
    logic [32:0] last_addr;
    logic [AW-1:0] a0, a1, a2, a3;
    logic [31:0] ld_data;

    // 33-bit end address so a request near 0xFFFFFFFF cannot wrap into range.
    always_comb begin
        case (size_q)
            2'b00:   nbytes = 33'd1;
            2'b01:   nbytes = 33'd2;
            default: nbytes = 33'd4;
        endcase
        last_addr = {1'b0, addr_q} + nbytes - 33'd1;
        acc_err   = (size_q == 2'b10)
                  | ((size_q == 2'b01) & addr_q[0])
                  | ((size_q == 2'b11) & (addr_q[1:0] != 2'b00))
                  | (last_addr >= 33'(SIZE));
    end

    assign a0 = addr_q[AW-1:0];
    assign a1 = a0 + AW'(1);
    assign a2 = a0 + AW'(2);
    assign a3 = a0 + AW'(3);

    // Big-endian assembly: lowest address lands in the most significant active byte.
    always_comb begin
        case (size_q)
            2'b00:   ld_data = {24'h0, mem[a0]};
            2'b01:   ld_data = {16'h0, mem[a0], mem[a1]};
            default: ld_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        error_d = error_q;
        access  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    size_d  = bus.req_size;
                    wdata_d = bus.req_wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    rdata_d = (acc_err || write_q) ? 32'h0 : ld_data;
                    error_d = acc_err;
                    state_d = StResp;
                end
            end
            StResp: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'h0;
            size_q  <= 2'b00;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    // Reset gates the commit so a store pending in WAIT is dropped.
    always_ff @(posedge clock) begin
        if (!reset && access && !acc_err && write_q) begin
            case (size_q)
                2'b00: mem[a0] <= wdata_q[7:0];
                2'b01: begin
                    mem[a0] <= wdata_q[15:8];
                    mem[a1] <= wdata_q[7:0];
                end
                default: begin
                    mem[a0] <= wdata_q[31:24];
                    mem[a1] <= wdata_q[23:16];
                    mem[a2] <= wdata_q[15:8];
                    mem[a3] <= wdata_q[7:0];
                end
            endcase
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_error = error_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of dmem_responder against a byte-array model.
module tb_dmem_responder;
    localparam int unsigned Size = 16384;
    localparam int unsigned Lat  = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    dmem_responder_if bus ();
    dmem_responder_if bus1 ();

    dmem_responder #(.SIZE(Size), .LATENCY(Lat)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    dmem_responder #(.SIZE(64), .LATENCY(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    always #5 clock = ~clock;

    // Reference storage: one entry per byte address written so far.
    logic [7:0] mm [int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_err(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b10) return 1'b1;
        if ((longint'(a) % nbytes(sz)) != 0) return 1'b1;
        return (longint'(a) + nbytes(sz) - 1) >= longint'(Size);
    endfunction

    task automatic model_access(input logic w, input logic [31:0] a, input logic [1:0] sz,
                                input logic [31:0] wd, output logic [31:0] rd,
                                output logic er);
        int n;
        n  = nbytes(sz);
        rd = 32'h0;
        er = model_err(a, sz);
        if (!er) begin
            for (int i = 0; i < n; i++) begin
                if (w) begin
                    mm[int'(a) + i] = 8'(wd >> (8 * (n - 1 - i)));
                end else begin
                    rd = (rd << 8) | (mm.exists(int'(a) + i) ? 32'(mm[int'(a) + i]) : 32'hx);
                end
            end
        end
    endtask

    // One complete transaction with resp_ready held high; checks latency and release.
    task automatic xact(input string tag, input logic w, input logic [31:0] a,
                        input logic [1:0] sz, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
        int n;
        int lat;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_addr   = a;
        bus.req_size   = sz;
        bus.req_wdata  = wd;
        bus.resp_ready = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (n >= 50) chk({tag, " accept"}, 32'(bus.req_ready), 32'd1);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        do begin
            @(posedge clock);
            #1;
            lat++;
        end while (!bus.resp_valid && lat < 40);
        chk({tag, " latency"}, 32'(lat), 32'(Lat));
        rd = bus.resp_rdata;
        er = bus.resp_error;
        @(posedge clock);
        #1;
        chk({tag, " release"}, {30'h0, bus.resp_valid, bus.req_ready}, 32'h1);
    endtask

    task automatic op(input string tag, input logic w, input logic [31:0] a,
                      input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] exp_rd, got_rd;
        logic        exp_er, got_er;
        model_access(w, a, sz, wd, exp_rd, exp_er);
        xact(tag, w, a, sz, wd, got_rd, got_er);
        chk({tag, " rdata"}, got_rd, exp_rd);
        chk({tag, " error"}, 32'(got_er), 32'(exp_er));
    endtask

    initial begin
        logic [31:0] held;
        logic        seen;
        logic [1:0]  sz;
        logic [31:0] a;

        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = 32'h0;
        bus.req_size    = 2'b00;
        bus.req_wdata   = 32'h0;
        bus.resp_ready  = 1'b0;
        bus1.req_valid  = 1'b0;
        bus1.req_write  = 1'b0;
        bus1.req_addr   = 32'h0;
        bus1.req_size   = 2'b00;
        bus1.req_wdata  = 32'h0;
        bus1.resp_ready = 1'b0;

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset req_ready", 32'(bus.req_ready), 32'd1);
        chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("reset resp_rdata", bus.resp_rdata, 32'h0);
        chk("reset resp_error", 32'(bus.resp_error), 32'd0);

        // Basic word round trip and narrow big-endian reads.
        op("st_w10", 1'b1, 32'h10, 2'b11, 32'hDEADBEEF);
        op("ld_w10", 1'b0, 32'h10, 2'b11, 32'h0);
        chk("ld_w10 literal", mm[16] == 8'hDE ? 32'h1 : 32'h0, 32'h1);
        op("ld_b10", 1'b0, 32'h10, 2'b00, 32'h0);
        op("ld_b13", 1'b0, 32'h13, 2'b00, 32'h0);
        op("ld_h12", 1'b0, 32'h12, 2'b01, 32'h0);

        // Byte store touches one byte only.
        op("st_b11", 1'b1, 32'h11, 2'b00, 32'h123456AA);
        op("ld_w10b", 1'b0, 32'h10, 2'b11, 32'h0);

        // Error cases must not disturb storage.
        op("st_w3ffc", 1'b1, 32'h3FFC, 2'b11, 32'h01020304);
        op("st_w0", 1'b1, 32'h0, 2'b11, 32'hA5A55A5A);
        op("ld_h11", 1'b0, 32'h11, 2'b01, 32'h0);
        op("st_w3ffe", 1'b1, 32'h3FFE, 2'b11, 32'hFFFFFFFF);
        op("st_sz10", 1'b1, 32'h0, 2'b10, 32'hFFFFFFFF);
        op("ld_w4000", 1'b0, 32'h4000, 2'b11, 32'h0);
        op("ld_big", 1'b0, 32'hFFFFFFFC, 2'b11, 32'h0);
        op("ld_w3ffc", 1'b0, 32'h3FFC, 2'b11, 32'h0);
        op("ld_w0", 1'b0, 32'h0, 2'b11, 32'h0);

        // Backpressure: response held, new request ignored.
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_addr   = 32'h10;
        bus.req_size   = 2'b11;
        bus.resp_ready = 1'b0;
        @(posedge clock);
        #1;
        bus.req_write  = 1'b1;
        bus.req_wdata  = 32'h77777777;
        repeat (Lat) @(posedge clock);
        #1;
        chk("bp valid", 32'(bus.resp_valid), 32'd1);
        held = bus.resp_rdata;
        chk("bp data", held, 32'hDEAABEEF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp hold valid", 32'(bus.resp_valid), 32'd1);
            chk("bp hold data", bus.resp_rdata, held);
            chk("bp hold ready", 32'(bus.req_ready), 32'd0);
        end
        @(negedge clock);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("bp done", {30'h0, bus.resp_valid, bus.req_ready}, 32'h1);
        op("bp ld_w10", 1'b0, 32'h10, 2'b11, 32'h0);

        // Reset during WAIT drops the pending store.
        op("st_b20", 1'b1, 32'h20, 2'b00, 32'h0);
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_size  = 2'b00;
        bus.req_wdata = 32'h55;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            seen = seen | bus.resp_valid;
        end
        chk("rst_wait no resp", 32'(seen), 32'd0);
        op("ld_b20", 1'b0, 32'h20, 2'b00, 32'h0);

        // Randomized traffic over a pre-filled window plus the top of storage.
        for (int i = 0; i < 32; i++) begin
            op("fill", 1'b1, 32'h100 + 32'(4 * i), 2'b11, $urandom);
        end
        for (int i = 0; i < 60; i++) begin
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a = Size - 4 + $urandom_range(0, 7);
            else a = 32'h100 + $urandom_range(0, 127);
            op("rand", 1'($urandom_range(0, 1)), a, sz, $urandom);
        end

        // LATENCY=1 build with requests held back-to-back: accept, WAIT, RESP, repeat.
        @(negedge clock);
        bus1.req_valid  = 1'b1;
        bus1.req_write  = 1'b1;
        bus1.req_addr   = 32'h0;
        bus1.req_size   = 2'b11;
        bus1.req_wdata  = 32'h12345678;
        bus1.resp_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("lat1 req_ready", 32'(bus1.req_ready), 32'((i % 3) == 0));
            chk("lat1 resp_valid", 32'(bus1.resp_valid), 32'((i % 3) == 2));
            if ((i % 3) == 2) begin
                chk("lat1 rdata", bus1.resp_rdata, 32'h0);
                chk("lat1 error", 32'(bus1.resp_error), 32'd0);
            end
            @(negedge clock);
        end
        bus1.req_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
